mips_run_ctrl: RTL and testbench

Run controller for the pipelined MIPS CPU top level. Sequences execution by driving a single global enable (`cpu_en`) to the PC and all pipeline registers. Supports free run, halt on syscall, and single-step via the `go` button. Optionally keeps execution statistics (cycles, taken branches, jumps, stall bubbles) for the LED/seven-segment display mux.

---
 rtl/mips_run_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_mips_run_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_run_ctrl.sv
//------------------------------------------------------------------------------
// mips_run_ctrl
//
// Run controller for the pipelined MIPS CPU top level. Drives one global
// enable (o_cpu_en) to the PC and every pipeline register, so the whole core
// either advances together or freezes together. Three run states:
//   RUN  (2'b00) : free running until a syscall halt or single-step mode.
//   HALT (2'b01) : frozen; a debounced-by-sync press of the go button resumes
//                  (step_mode=0) or advances exactly one cycle (step_mode=1).
//   STEP (2'b10) : one enabled cycle, then back to HALT.
//
// Optional feature macro: MIPS_STAT_CNT_EN
//   defined   -> cycle / taken-branch / jump / stall-bubble counters are built.
//   undefined -> no counter registers; counter outputs are tied to zero.
//
// Parameters:
//   CNT_W     width of every statistics counter (wraps, no saturation)
//   START_RUN 1: come out of reset in RUN, 0: come out of reset in HALT
//
// Ports:
//   i_clk            system clock, rising edge
//   i_rst            asynchronous active-high reset
//   i_go             raw push-button, asynchronous to i_clk
//   i_step_mode      1 = single-step, 0 = free run
//   i_halt_req       syscall halt from the datapath (level)
//   i_stall_in       load-use bubble inserted this cycle
//   i_branch_taken   conditional branch resolved taken this cycle
//   i_jump           j/jal/jr committed this cycle
//   i_stat_clr       synchronous clear of all statistics counters
//   o_cpu_en         global PC / pipeline enable
//   o_halted         high while in HALT
//   o_state          encoded run state (RUN=00, HALT=01, STEP=10)
//   o_cycle_cnt      enabled cycles
//   o_branch_cnt     taken branches while enabled
//   o_jump_cnt       jumps while enabled
//   o_stall_cnt      stall bubbles while enabled
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mips_run_ctrl #(
    parameter int CNT_W     = 32,
    parameter bit START_RUN = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_go,
    input  logic             i_step_mode,
    input  logic             i_halt_req,
    input  logic             i_stall_in,
    input  logic             i_branch_taken,
    input  logic             i_jump,
    input  logic             i_stat_clr,
    output logic             o_cpu_en,
    output logic             o_halted,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_jump_cnt,
    output logic [CNT_W-1:0] o_stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'b00,
        ST_HALT = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    localparam state_t RST_STATE = START_RUN ? ST_RUN : ST_HALT;

    logic   r_go_meta;
    logic   r_go_sync;
    logic   r_go_dly;
    logic   w_go_edge;
    state_t r_state;
    logic   w_cpu_en;
    logic   w_halt_qual;

    //--------------------------------------------------------------------------
    // go button: two-flop synchronizer plus a delay flop for edge detection.
    // Holding the button produces a single pulse; it must be released before
    // another press is recognised.
    //--------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge value of its neighbour; blocking here would collapse the
    // synchronizer chain into a single flop.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_go_meta <= 1'b0;
            r_go_sync <= 1'b0;
            r_go_dly  <= 1'b0;
        end else begin
            r_go_meta <= i_go;
            r_go_sync <= r_go_meta;
            r_go_dly  <= r_go_sync;
        end
    end

    assign w_go_edge = r_go_sync & ~r_go_dly;

    // Enable is a pure decode of the state register, so it changes only
    // right after a clock edge and never glitches on input activity.
    assign w_cpu_en = (r_state != ST_HALT);

    // The datapath only flags a syscall while it is actually executing.
    assign w_halt_qual = i_halt_req & w_cpu_en;

    //--------------------------------------------------------------------------
    // Run state machine. A go pulse arriving outside HALT is dropped.
    //--------------------------------------------------------------------------
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= RST_STATE;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_halt_qual || i_step_mode) begin
                        r_state <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    if (w_go_edge) begin
                        r_state <= i_step_mode ? ST_STEP : ST_RUN;
                    end
                end
                ST_STEP: r_state <= ST_HALT;
                // Unused encoding: park safely with the core frozen.
                default: r_state <= ST_HALT;
            endcase
        end
    end

    assign o_cpu_en = w_cpu_en;
    assign o_halted = (r_state == ST_HALT);
    assign o_state  = r_state;

    //--------------------------------------------------------------------------
    // Statistics counters (optional).
    //--------------------------------------------------------------------------
`ifdef MIPS_STAT_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_jump_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    // Clear wins over a same-cycle increment; counters wrap naturally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cycle_cnt  <= '0;
            r_branch_cnt <= '0;
            r_jump_cnt   <= '0;
            r_stall_cnt  <= '0;
        end else if (i_stat_clr) begin
            r_cycle_cnt  <= '0;
            r_branch_cnt <= '0;
            r_jump_cnt   <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (w_cpu_en) begin
                r_cycle_cnt <= r_cycle_cnt + CNT_ONE;
            end
            if (w_cpu_en && i_branch_taken) begin
                r_branch_cnt <= r_branch_cnt + CNT_ONE;
            end
            if (w_cpu_en && i_jump) begin
                r_jump_cnt <= r_jump_cnt + CNT_ONE;
            end
            if (w_cpu_en && i_stall_in) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
        end
    end

    assign o_cycle_cnt  = r_cycle_cnt;
    assign o_branch_cnt = r_branch_cnt;
    assign o_jump_cnt   = r_jump_cnt;
    assign o_stall_cnt  = r_stall_cnt;
`else
    // Statistics disabled: inputs that only feed the counters are sunk here.
    logic w_unused_stat;
    assign w_unused_stat = ^{i_stat_clr, i_stall_in, i_branch_taken, i_jump};

    assign o_cycle_cnt  = '0;
    assign o_branch_cnt = '0;
    assign o_jump_cnt   = '0;
    assign o_stall_cnt  = '0;
`endif

endmodule

// File: tb/tb_mips_run_ctrl.sv
`timescale 1ns/1ps

module tb_mips_run_ctrl;

    localparam int W0 = 32;
    localparam int W1 = 4;

    // Spec-level run states (numeric values are the documented encoding).
    localparam int S_RUN  = 0;
    localparam int S_HALT = 1;
    localparam int S_STEP = 2;

    logic clk;
    logic rst;
    logic go, step_mode, halt_req, stall_in, branch_taken, jump, stat_clr;

    logic          en0, halted0;
    logic [1:0]    st0;
    logic [W0-1:0] cyc0, br0, jp0, sl0;
    logic          en1, halted1;
    logic [1:0]    st1;
    logic [W1-1:0] cyc1, br1, jp1, sl1;

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: 32-bit counters, starts running.
    mips_run_ctrl #(.CNT_W(W0), .START_RUN(1'b1)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_step_mode(step_mode),
        .i_halt_req(halt_req), .i_stall_in(stall_in),
        .i_branch_taken(branch_taken), .i_jump(jump), .i_stat_clr(stat_clr),
        .o_cpu_en(en0), .o_halted(halted0), .o_state(st0),
        .o_cycle_cnt(cyc0), .o_branch_cnt(br0), .o_jump_cnt(jp0),
        .o_stall_cnt(sl0)
    );

    // Instance 1: 4-bit counters (wrap), starts halted.
    mips_run_ctrl #(.CNT_W(W1), .START_RUN(1'b0)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_go(go), .i_step_mode(step_mode),
        .i_halt_req(halt_req), .i_stall_in(stall_in),
        .i_branch_taken(branch_taken), .i_jump(jump), .i_stat_clr(stat_clr),
        .o_cpu_en(en1), .o_halted(halted1), .o_state(st1),
        .o_cycle_cnt(cyc1), .o_branch_cnt(br1), .o_jump_cnt(jp1),
        .o_stall_cnt(sl1)
    );

    //--------------------------------------------------------------------------
    // Reference model: per-instance run state and counter totals, plus the
    // history of go values seen at the last three clock edges.
    //--------------------------------------------------------------------------
    int     m_state [2];
    longint m_cyc   [2];
    longint m_br    [2];
    longint m_jp    [2];
    longint m_sl    [2];
    bit     go_hist [$];   // oldest first: go at edges e-3, e-2, e-1

    function automatic longint wrap(input longint v, input int w);
        return v % (longint'(1) << w);
    endfunction

    function automatic longint exp_cnt(input longint v);
`ifdef MIPS_STAT_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    function automatic void model_reset();
        m_state[0] = S_RUN;
        m_state[1] = S_HALT;
        for (int i = 0; i < 2; i++) begin
            m_cyc[i] = 0; m_br[i] = 0; m_jp[i] = 0; m_sl[i] = 0;
        end
        go_hist = '{1'b0, 1'b0, 1'b0};
    endfunction

    // One rising edge with the currently driven inputs.
    function automatic void model_edge();
        bit press;
        press = go_hist[1] && !go_hist[0];   // newly-high go, two edges old
        for (int i = 0; i < 2; i++) begin
            int w;
            bit en;
            w  = (i == 0) ? W0 : W1;
            en = (m_state[i] != S_HALT);
            if (stat_clr) begin
                m_cyc[i] = 0; m_br[i] = 0; m_jp[i] = 0; m_sl[i] = 0;
            end else begin
                m_cyc[i] = wrap(m_cyc[i] + longint'(en), w);
                m_br[i]  = wrap(m_br[i] + longint'(en && branch_taken), w);
                m_jp[i]  = wrap(m_jp[i] + longint'(en && jump), w);
                m_sl[i]  = wrap(m_sl[i] + longint'(en && stall_in), w);
            end
            if (m_state[i] == S_RUN) begin
                if (halt_req || step_mode) m_state[i] = S_HALT;
            end else if (m_state[i] == S_HALT) begin
                if (press) m_state[i] = step_mode ? S_STEP : S_RUN;
            end else begin
                m_state[i] = S_HALT;
            end
        end
        go_hist.push_back(go);
        void'(go_hist.pop_front());
    endfunction

    //--------------------------------------------------------------------------
    // Checking helpers
    //--------------------------------------------------------------------------
    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp,
                     $time);
        end
    endtask

    task automatic check_all(input string tag);
        check($sformatf("%s st0", tag), 64'(st0), 64'(m_state[0]));
        check($sformatf("%s en0", tag), 64'(en0), 64'(m_state[0] != S_HALT));
        check($sformatf("%s hl0", tag), 64'(halted0), 64'(m_state[0] == S_HALT));
        check($sformatf("%s cyc0", tag), 64'(cyc0), exp_cnt(m_cyc[0]));
        check($sformatf("%s br0", tag), 64'(br0), exp_cnt(m_br[0]));
        check($sformatf("%s jp0", tag), 64'(jp0), exp_cnt(m_jp[0]));
        check($sformatf("%s sl0", tag), 64'(sl0), exp_cnt(m_sl[0]));
        check($sformatf("%s st1", tag), 64'(st1), 64'(m_state[1]));
        check($sformatf("%s en1", tag), 64'(en1), 64'(m_state[1] != S_HALT));
        check($sformatf("%s hl1", tag), 64'(halted1), 64'(m_state[1] == S_HALT));
        check($sformatf("%s cyc1", tag), 64'(cyc1), exp_cnt(m_cyc[1]));
        check($sformatf("%s br1", tag), 64'(br1), exp_cnt(m_br[1]));
        check($sformatf("%s jp1", tag), 64'(jp1), exp_cnt(m_jp[1]));
        check($sformatf("%s sl1", tag), 64'(sl1), exp_cnt(m_sl[1]));
    endtask

    // Inputs are already driven; advance one edge and compare at the negedge.
    task automatic cyc(input string tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must react at once.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all("rst_async");
        @(posedge clk);
        @(negedge clk);
        check_all("rst_hold");
        #1 rst = 1'b0;
    endtask

    task automatic set_in(input bit g, input bit sm, input bit hr);
        go = g; step_mode = sm; halt_req = hr;
    endtask

    //--------------------------------------------------------------------------
    // Directed state-sequence table (instance 0, START_RUN=1, from reset).
    //--------------------------------------------------------------------------
    typedef struct {
        bit       go;
        bit       sm;
        bit       hr;
        bit [1:0] st;
        bit       en;
        bit       hl;
    } vec_t;

    vec_t tbl [21];

    initial begin
        int npulse;
        int pos;

        tbl = '{
            '{0, 0, 0, 2'd0, 1, 0},   // free run
            '{0, 0, 1, 2'd1, 0, 1},   // syscall halt
            '{0, 0, 1, 2'd1, 0, 1},   // halt_req ignored in HALT
            '{1, 0, 0, 2'd1, 0, 1},   // press
            '{1, 0, 0, 2'd1, 0, 1},
            '{0, 0, 0, 2'd0, 1, 0},   // press seen -> RUN
            '{0, 1, 0, 2'd1, 0, 1},   // step_mode stops RUN
            '{1, 1, 0, 2'd1, 0, 1},   // press in step mode
            '{0, 1, 0, 2'd1, 0, 1},
            '{0, 1, 0, 2'd2, 1, 0},   // STEP
            '{0, 1, 0, 2'd1, 0, 1},   // back to HALT
            '{0, 1, 0, 2'd1, 0, 1},
            '{1, 0, 0, 2'd1, 0, 1},   // held press, free-run mode
            '{1, 0, 0, 2'd1, 0, 1},
            '{1, 0, 0, 2'd0, 1, 0},   // single edge -> RUN
            '{0, 0, 0, 2'd0, 1, 0},
            '{1, 0, 0, 2'd0, 1, 0},   // press while running
            '{0, 0, 0, 2'd0, 1, 0},
            '{0, 0, 1, 2'd1, 0, 1},   // halt; the press is dropped
            '{0, 0, 0, 2'd1, 0, 1},   // not queued
            '{0, 0, 0, 2'd1, 0, 1}
        };

        rst = 1'b0;
        set_in(0, 0, 0);
        stall_in = 0; branch_taken = 0; jump = 0; stat_clr = 0;

        // --- reset release, free run for 10 cycles
        do_reset();
        check("rst_cyc0", 64'(cyc0), 64'd0);
        check("rst_st1", 64'(st1), 64'd1);
        for (int i = 0; i < 10; i++) begin
            cyc("run10");
            check("run10_en", 64'(en0), 64'd1);
        end
        check("run10_cyc", 64'(cyc0), exp_cnt(10));
        check("run10_st", 64'(st0), 64'd0);

        // --- table-driven state sequence
        do_reset();
        for (int i = 0; i < 21; i++) begin
            set_in(tbl[i].go, tbl[i].sm, tbl[i].hr);
            cyc($sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_state", i), 64'(st0), 64'(tbl[i].st));
            check($sformatf("tbl%0d_en", i), 64'(en0), 64'(tbl[i].en));
            check($sformatf("tbl%0d_halted", i), 64'(halted0), 64'(tbl[i].hl));
        end
        set_in(0, 0, 0);

        // --- halt_req at cycle 21 after reset
        do_reset();
        for (int i = 0; i < 20; i++) cyc("pre_halt");
        halt_req = 1;
        cyc("halt");
        halt_req = 0;
        check("halt_cyc", 64'(cyc0), exp_cnt(21));
        check("halt_en", 64'(en0), 64'd0);
        check("halt_halted", 64'(halted0), 64'd1);
        for (int i = 0; i < 6; i++) begin
            halt_req = (i % 2 == 0);
            cyc("halt_ign");
        end
        halt_req = 0;
        check("halt_ign_cyc", 64'(cyc0), exp_cnt(21));
        check("halt_ign_en", 64'(en0), 64'd0);

        // --- three single-step presses
        step_mode = 1;
        for (int p = 0; p < 3; p++) begin
            npulse = 0;
            pos = -1;
            for (int j = 0; j < 6; j++) begin
                go = (j == 0);
                cyc("step");
                if (en0) begin
                    npulse++;
                    pos = j;
                end
            end
            check($sformatf("step%0d_pulses", p), 64'(npulse), 64'd1);
            check($sformatf("step%0d_pos", p), 64'(pos), 64'd2);
        end
        check("step_cyc", 64'(cyc0), exp_cnt(24));
        step_mode = 0;

        // --- branch/jump/stall counting with clear priority
        do_reset();
        stat_clr = 1; jump = 1; branch_taken = 1;
        cyc("clr");
        stat_clr = 0; jump = 0;
        for (int i = 0; i < 5; i++) begin
            stall_in = (i == 1 || i == 2);
            halt_req = (i == 4);
            cyc("br_run");
        end
        stall_in = 0; halt_req = 0;
        for (int i = 0; i < 2; i++) cyc("br_halt");
        branch_taken = 0;
        check("br_cnt", 64'(br0), exp_cnt(5));
        check("jp_cnt", 64'(jp0), exp_cnt(0));
        check("sl_cnt", 64'(sl0), exp_cnt(2));
        check("br_cyc", 64'(cyc0), exp_cnt(5));

        // --- 4-bit wrap on instance 1 (17 enabled cycles)
        do_reset();
        go = 1;
        cyc("wrap");
        go = 0;
        for (int i = 0; i < 19; i++) cyc("wrap");
        check("wrap_cyc1", 64'(cyc1), exp_cnt(1));
        check("wrap_cyc0", 64'(cyc0), exp_cnt(20));

        // --- reset while instance 1 is in STEP, go held across release
        step_mode = 1;
        cyc("to_halt");
        go = 1;
        cyc("step_press");
        go = 0;
        cyc("step_wait");
        cyc("step_in");
        check("in_step_st1", 64'(st1), 64'd2);
        go = 1;
        do_reset();
        check("stprst_st1", 64'(st1), 64'd1);
        check("stprst_en1", 64'(en1), 64'd0);
        check("stprst_cyc1", 64'(cyc1), 64'd0);
        check("stprst_st0", 64'(st0), 64'd0);
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            cyc("held_go");
            if (en1) npulse++;
        end
        check("held_go_steps", 64'(npulse), 64'd1);
        go = 0;
        step_mode = 0;

        // --- randomized traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(5) == 0) go = ~go;
            if ($urandom_range(39) == 0) step_mode = ~step_mode;
            halt_req     = ($urandom_range(7) == 0);
            branch_taken = $urandom_range(1);
            jump         = $urandom_range(1);
            stall_in     = $urandom_range(1);
            stat_clr     = ($urandom_range(49) == 0);
            if ($urandom_range(399) == 0) do_reset();
            cyc("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
